iter_mdu: RTL

ITER_MDU -- requirements
Module: iter_mdu

---
 rtl/iter_mdu.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/iter_mdu.sv
// iter_mdu: iterative multiply / divide unit processing one operand bit per cycle.
// Shift-add multiply and restoring divide share one 2*WIDTH accumulator.
module iter_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_div,
  input  logic             sign,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state_r;
  state_t             state_next_s;
  logic [CW-1:0]      cnt_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] calc_next_s;
  logic [2*WIDTH-1:0] prod_s;
  logic [WIDTH-1:0]   mcand_r;
  logic [WIDTH-1:0]   a_mag_s;
  logic [WIDTH-1:0]   b_mag_s;
  logic [WIDTH-1:0]   quot_s;
  logic [WIDTH-1:0]   rem_s;
  logic [WIDTH-1:0]   rem_sub_s;
  logic [WIDTH:0]     sum_s;
  logic [WIDTH:0]     shifted_s;
  logic               ge_s;
  logic               b_zero_s;
  logic               op_div_r;
  logic               neg_q_r;
  logic               neg_r_r;
  logic               dz_r;
  logic               busy_r;
  logic               done_r;
  logic               div_zero_r;
  logic [WIDTH-1:0]   lo_r;
  logic [WIDTH-1:0]   hi_r;

  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                 input logic is_signed);
    if (is_signed && x[WIDTH-1]) begin
      return -x;
    end else begin
      return x;
    end
  endfunction

  assign a_mag_s  = magnitude(a, sign);
  assign b_mag_s  = magnitude(b, sign);
  assign b_zero_s = (b == {WIDTH{1'b0}});

  // Next-state logic; a zero divisor skips the iterative phase entirely.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = (op_div && b_zero_s) ? SIGN : CALC;
        end else begin
          state_next_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == CNT_LAST) begin
          state_next_s = SIGN;
        end else begin
          state_next_s = CALC;
        end
      end
      SIGN:    state_next_s = DONE;
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // One iteration step plus the final sign correction of the magnitude results.
  always_comb begin
    calc_next_s = acc_r;
    sum_s       = {1'b0, acc_r[2*WIDTH-1:WIDTH]} +
                  (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    shifted_s   = {acc_r[2*WIDTH-1:WIDTH], acc_r[WIDTH-1]};
    ge_s        = (shifted_s >= {1'b0, mcand_r});
    // The true difference is below the divisor, so WIDTH bits suffice.
    rem_sub_s   = shifted_s[WIDTH-1:0] - mcand_r;
    if (op_div_r) begin
      if (ge_s) begin
        calc_next_s = {rem_sub_s, acc_r[WIDTH-2:0], 1'b1};
      end else begin
        calc_next_s = {shifted_s[WIDTH-1:0], acc_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      calc_next_s = {sum_s, acc_r[WIDTH-1:1]};
    end
    prod_s = neg_q_r ? -acc_r : acc_r;
    quot_s = neg_q_r ? -acc_r[WIDTH-1:0] : acc_r[WIDTH-1:0];
    rem_s  = neg_r_r ? -acc_r[2*WIDTH-1:WIDTH] : acc_r[2*WIDTH-1:WIDTH];
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Datapath registers and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r      <= {CW{1'b0}};
      acc_r      <= {(2*WIDTH){1'b0}};
      mcand_r    <= {WIDTH{1'b0}};
      op_div_r   <= 1'b0;
      neg_q_r    <= 1'b0;
      neg_r_r    <= 1'b0;
      dz_r       <= 1'b0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      div_zero_r <= 1'b0;
      lo_r       <= {WIDTH{1'b0}};
      hi_r       <= {WIDTH{1'b0}};
    end else begin
      busy_r <= (state_next_s == CALC) || (state_next_s == SIGN);
      done_r <= (state_r == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            op_div_r <= op_div;
            mcand_r  <= b_mag_s;
            neg_q_r  <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_r_r  <= sign & a[WIDTH-1];
            cnt_r    <= {CW{1'b0}};
            if (op_div && b_zero_s) begin
              dz_r  <= 1'b1;
              acc_r <= {{WIDTH{1'b0}}, a};
            end else begin
              dz_r  <= 1'b0;
              acc_r <= {{WIDTH{1'b0}}, a_mag_s};
            end
          end
        end
        CALC: begin
          acc_r <= calc_next_s;
          cnt_r <= cnt_r + CW'(1);
        end
        SIGN: begin
          div_zero_r <= dz_r;
          if (dz_r) begin
            lo_r <= {WIDTH{1'b1}};
            hi_r <= acc_r[WIDTH-1:0];
          end else if (op_div_r) begin
            lo_r <= quot_s;
            hi_r <= rem_s;
          end else begin
            lo_r <= prod_s[WIDTH-1:0];
            hi_r <= prod_s[2*WIDTH-1:WIDTH];
          end
        end
        DONE: begin
          cnt_r <= {CW{1'b0}};
        end
        default: begin
          cnt_r <= {CW{1'b0}};
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign lo       = lo_r;
  assign hi       = hi_r;
  assign div_zero = div_zero_r;

endmodule
